// File: rtl/win_mul_seq.sv
// rtl/win_mul_seq.sv - multi-cycle signed shift-add multiplier with valid/ready handshakes
//
// Purpose: converts two W-bit two's-complement operands to sign + magnitude,
// multiplies the magnitudes BPC multiplier bits per cycle (ITER = W/BPC cycles),
// and returns the exact 2W-bit two's-complement product. The optional running
// accumulator is enabled by defining the macro WIN_MUL_ACC_EN.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept an operand pair
//   mul_a      multiplicand, W bits, two's complement
//   mul_b      multiplier, W bits, two's complement
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   mul_out    product, 2W bits, two's complement
//   acc_clear  (WIN_MUL_ACC_EN) clear accumulator before adding this product
//   acc_out    (WIN_MUL_ACC_EN) running sum, ACC_W bits, wraps modulo 2^ACC_W

module win_mul_seq #(
  parameter int W     = 8,
  parameter int BPC   = 1,
  parameter int ACC_W = 2*W+4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     mul_a,
  input  logic [W-1:0]     mul_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   mul_out
`ifdef WIN_MUL_ACC_EN
  ,
  input  logic             acc_clear,
  output logic [ACC_W-1:0] acc_out
`endif
);

  localparam int ITER  = W / BPC;
  localparam int CNT_W = $clog2(ITER + 1);

  if (W < 4 || W > 16 || !(BPC == 1 || BPC == 2 || BPC == 4) ||
      (W % BPC) != 0 || ACC_W < 2*W) begin : g_bad_param
    $error("win_mul_seq: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Multiplicand magnitude is kept 2W wide and shifted left each iteration so
  // the partial product lands at the current bit position without a barrel shifter.
  logic [2*W-1:0]   mag_a_q, mag_a_d;
  logic [W-1:0]     mag_b_q, mag_b_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
  logic [2*W-1:0]   prod_q, prod_d;
  logic [2*W-1:0]   res_q, res_d;

  logic             accept;
  logic             last_iter;
  logic [W-1:0]     abs_a, abs_b;
  logic [2*W-1:0]   pp;
  logic [2*W-1:0]   prod_sum;
  logic [2*W-1:0]   prod_fin;

  assign accept    = in_valid & in_ready;
  assign last_iter = (state_q == S_BUSY) && (cnt_q == CNT_W'(ITER - 1));

  // Two's-complement negate of the most-negative value yields 2^(W-1), which
  // is exactly the required magnitude when read as unsigned.
  assign abs_a = mul_a[W-1] ? (~mul_a + W'(1)) : mul_a;
  assign abs_b = mul_b[W-1] ? (~mul_b + W'(1)) : mul_b;

  always_comb begin
    pp = '0;
    for (int j = 0; j < BPC; j++) begin
      if (mag_b_q[j]) begin
        pp = pp + (mag_a_q << j);
      end
    end
  end

  assign prod_sum = prod_q + pp;
  // Forcing zero here keeps a negative sign from ever producing -0.
  assign prod_fin = zero_q ? '0 : (sign_q ? (-prod_sum) : prod_sum);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_BUSY;
      S_BUSY: if (last_iter) state_d = S_DONE;
      S_DONE: begin
        if (accept)         state_d = S_BUSY;
        else if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    out_valid = (state_q == S_DONE);
  end

  // Datapath next-state
  always_comb begin
    cnt_d   = cnt_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    prod_d  = prod_q;
    res_d   = res_q;
    if (accept) begin
      cnt_d   = '0;
      mag_a_d = {{W{1'b0}}, abs_a};
      mag_b_d = abs_b;
      sign_d  = mul_a[W-1] ^ mul_b[W-1];
      zero_d  = (mul_a == '0) || (mul_b == '0);
      prod_d  = '0;
    end else if (state_q == S_BUSY) begin
      cnt_d   = cnt_q + CNT_W'(1);
      mag_a_d = mag_a_q << BPC;
      mag_b_d = mag_b_q >> BPC;
      prod_d  = prod_sum;
      if (last_iter) begin
        res_d = prod_fin;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      prod_q  <= '0;
      res_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
    end
  end

  assign mul_out = res_q;

`ifdef WIN_MUL_ACC_EN
  logic             acc_clr_q, acc_clr_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_clr_d = acc_clr_q;
    acc_d     = acc_q;
    if (accept) begin
      acc_clr_d = acc_clear;
    end
    // Updated on the same edge that registers mul_out, so acc_out moves with out_valid.
    if (last_iter) begin
      acc_d = (acc_clr_q ? '0 : acc_q) + ACC_W'($signed(prod_fin));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_clr_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      acc_clr_q <= acc_clr_d;
      acc_q     <= acc_d;
    end
  end

  assign acc_out = acc_q;
`endif

endmodule
